// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder/subtractor: one 4-bit ripple slice per cycle, LSB first.
// Results are published only on completion; partial sums stay internal.
module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   sub,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout,
   output logic                   ovf
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic          sub_q;
   logic [IW-1:0] idx;
   logic          carry;
   logic [W-1:0]  acc;

   logic [3:0]    nib_a;
   logic [3:0]    nib_b;
   logic [4:0]    sum;
   logic          c_msb;
   logic [W-1:0]  acc_nx;
   logic          last;
   logic          accept;

   assign busy   = (state == CALC);
   assign done   = (state == DONE);
   assign accept = start && (state != CALC);
   assign last   = (idx == IW'(NIBBLES - 1));

   always_comb begin
      nib_a  = a_q[{idx, 2'b00} +: 4];
      nib_b  = b_q[{idx, 2'b00} +: 4] ^ {4{sub_q}};
      sum    = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
      // carry into the top bit of this slice, recovered from its sum bit
      c_msb  = nib_a[3] ^ nib_b[3] ^ sum[3];
      acc_nx = acc;
      acc_nx[{idx, 2'b00} +: 4] = sum[3:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         sub_q  <= 1'b0;
         idx    <= '0;
         carry  <= 1'b0;
         acc    <= '0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            CALC: begin
               acc   <= acc_nx;
               carry <= sum[4];
               idx   <= idx + 1'b1;
               if (last) begin
                  state  <= DONE;
                  result <= acc_nx;
                  cout   <= sum[4];
                  ovf    <= c_msb ^ sum[4];
               end
            end
            default: begin
               if (accept) begin
                  state <= CALC;
                  a_q   <= op_a;
                  b_q   <= op_b;
                  sub_q <= sub;
                  idx   <= '0;
                  carry <= sub;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (NIBBLES=4).
// Directed corner cases plus random ops against an integer reference model.
module tb_nibble_serial_add_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sub;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        cout;
   logic        ovf;

   int total;
   int bad;
   logic [15:0] prev_res;
   logic        prev_cout;

   nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .sub    (sub),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic on the operand values.
   task automatic model(input logic s, input logic [15:0] a,
                        input logic [15:0] b, output logic [15:0] r,
                        output logic c, output logic v);
      int ai, bi, sa, sb, full, sr;
      ai = int'(a);
      bi = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (s) begin
         full = ai - bi;
         c    = (ai >= bi);
         sr   = sa - sb;
      end else begin
         full = ai + bi;
         c    = (full > 65535);
         sr   = sa + sb;
      end
      r = 16'(full & 32'hFFFF);
      v = (sr > 32767) || (sr < -32768);
   endtask

   // Enter from a cycle where the DUT can accept; leave in the DONE cycle.
   task automatic do_op(input logic s, input logic [15:0] a,
                        input logic [15:0] b, input bit noise);
      logic [15:0] er;
      logic ec, ev;
      model(s, a, b, er, ec, ev);
      start = 1'b1;
      sub   = s;
      op_a  = a;
      op_b  = b;
      tick();
      for (int i = 1; i <= 4; i++) begin
         check("busy_calc", 32'(busy), 32'd1);
         check("done_calc", 32'(done), 32'd0);
         check("res_hold", 32'(result), 32'(prev_res));
         check("cout_hold", 32'(cout), 32'(prev_cout));
         start = noise;
         sub   = 1'($urandom);
         op_a  = 16'($urandom);
         op_b  = 16'($urandom);
         tick();
      end
      start = 1'b0;
      check("done_pulse", 32'(done), 32'd1);
      check("busy_done", 32'(busy), 32'd0);
      check("result", 32'(result), 32'(er));
      check("cout", 32'(cout), 32'(ec));
      check("ovf", 32'(ovf), 32'(ev));
      prev_res  = er;
      prev_cout = ec;
   endtask

   task automatic idle_cycle();
      tick();
      check("busy_idle", 32'(busy), 32'd0);
      check("done_idle", 32'(done), 32'd0);
      check("res_idle", 32'(result), 32'(prev_res));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      prev_res  = '0;
      prev_cout = 1'b0;
      rst_n = 1'b0;
      start = 1'b1;
      sub   = 1'b0;
      op_a  = 16'h1111;
      op_b  = 16'h2222;
      tick();
      start = 1'b0;
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      idle_cycle();

      // first op with start held during CALC, then back-to-back chain
      do_op(1'b0, 16'h1234, 16'h0FFF, 1'b1);
      do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
      do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
      idle_cycle();
      do_op(1'b1, 16'h0005, 16'h0007, 1'b0);
      do_op(1'b1, 16'h8000, 16'h0001, 1'b0);
      idle_cycle();
      idle_cycle();

      // reset in cycle 2 of an operation, start held alongside
      start = 1'b1;
      sub   = 1'b0;
      op_a  = 16'h00FF;
      op_b  = 16'h0F0F;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      start = 1'b1;
      tick();
      rst_n = 1'b1;
      start = 1'b0;
      prev_res  = '0;
      prev_cout = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_cout", 32'(cout), 32'd0);
      check("abort_ovf", 32'(ovf), 32'd0);
      for (int i = 0; i < 6; i++) idle_cycle();

      for (int n = 0; n < 60; n++) begin
         do_op(1'($urandom), 16'($urandom), 16'($urandom),
               bit'($urandom_range(0, 1)));
         for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
      end
      idle_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
